// File: rtl/beamformer_sequencer_if.sv
// Control/status bundle between the beamformer phase sequencer and the datapath.
// master: sequencer side; slave: datapath (or bench) side.
interface beamformer_sequencer_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              start;
    logic              filt_valid;
    logic              bf_data_good;
    logic [ADDR_W-1:0] signal_address;
    logic              signalinen;
    logic              filt_sink_valid;
    logic [ADDR_W-1:0] readin_address;
    logic              filter_bram_output_write_en;
    logic              output_read_en;
    logic              startbeamformer;
    logic [1:0]        slice_state;
    logic [15:0]       sample_index;
    logic [ADDR_W-1:0] sumout_address;
    logic              sumouten;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, filt_valid, bf_data_good,
        output signal_address, signalinen, filt_sink_valid, readin_address,
               filter_bram_output_write_en, output_read_en, startbeamformer, slice_state,
               sample_index, sumout_address, sumouten, busy, done, err
    );

    modport slave (
        output start, filt_valid, bf_data_good,
        input  signal_address, signalinen, filt_sink_valid, readin_address,
               filter_bram_output_write_en, output_read_en, startbeamformer, slice_state,
               sample_index, sumout_address, sumouten, busy, done, err
    );
endinterface

// File: rtl/beamformer_sequencer.sv
// Phase controller for the filter/beamformer datapath: FILTER -> BEAM -> DRAIN -> (READOUT) -> DONE.
// Define BFSEQ_READOUT_EN to build the READOUT sweep of the sum RAM; otherwise DRAIN ends in DONE.
module beamformer_sequencer #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned NUM_WORDS = 512,
    parameter int unsigned DRAIN_MAX = 64
) (
    input logic                    clk,
    input logic                    rst,
    beamformer_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] LastWord  = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] NumWords  = ADDR_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LastSum   = ADDR_W'(3 * NUM_WORDS - 1);
    localparam logic [ADDR_W:0]   TotalCnt  = (ADDR_W + 1)'(3 * NUM_WORDS);
    localparam logic [15:0]       DrainLast = 16'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {StIdle, StFilter, StBeam, StDrain, StReadout, StDone} state_e;

    state_e            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W:0]   good_cnt;
    logic [15:0]       drain_timer;
    logic              strobe;
    logic [ADDR_W:0]   good_next;

    // Strobe count including this cycle's strobe, so a completing strobe beats the timeout.
    always_comb begin
        strobe    = ((state == StBeam) || (state == StDrain)) && bus.bf_data_good;
        good_next = good_cnt;
        if (strobe && (good_cnt != TotalCnt)) begin
            good_next = good_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                           <= StIdle;
            wr_cnt                          <= '0;
            good_cnt                        <= '0;
            drain_timer                     <= '0;
            bus.signal_address              <= '0;
            bus.signalinen                  <= 1'b0;
            bus.filt_sink_valid             <= 1'b0;
            bus.readin_address              <= '0;
            bus.filter_bram_output_write_en <= 1'b0;
            bus.output_read_en              <= 1'b0;
            bus.startbeamformer             <= 1'b0;
            bus.slice_state                 <= '0;
            bus.sample_index                <= '0;
            bus.sumout_address              <= '0;
            bus.sumouten                    <= 1'b0;
            bus.busy                        <= 1'b0;
            bus.done                        <= 1'b0;
            bus.err                         <= 1'b0;
        end else begin
            bus.filt_sink_valid             <= bus.signalinen;
            bus.filter_bram_output_write_en <= 1'b0;
            good_cnt                        <= good_next;
            if (strobe && (bus.sumout_address != LastSum)) begin
                bus.sumout_address <= bus.sumout_address + 1'b1;
            end

            unique case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state              <= StFilter;
                        wr_cnt             <= '0;
                        good_cnt           <= '0;
                        bus.signalinen     <= 1'b1;
                        bus.signal_address <= '0;
                        bus.readin_address <= '0;
                        bus.slice_state    <= '0;
                        bus.sample_index   <= '0;
                        bus.sumout_address <= '0;
                        bus.busy           <= 1'b1;
                        bus.done           <= 1'b0;
                        bus.err            <= 1'b0;
                    end
                end

                StFilter: begin
                    if (bus.signalinen) begin
                        if (bus.signal_address == LastWord) begin
                            bus.signalinen <= 1'b0;
                        end else begin
                            bus.signal_address <= bus.signal_address + 1'b1;
                        end
                    end
                    if (wr_cnt == NumWords) begin
                        state               <= StBeam;
                        bus.signalinen      <= 1'b0;
                        bus.readin_address  <= '0;
                        bus.startbeamformer <= 1'b1;
                        bus.output_read_en  <= 1'b1;
                        bus.slice_state     <= '0;
                    end else if (bus.filt_valid) begin
                        bus.filter_bram_output_write_en <= 1'b1;
                        bus.readin_address              <= wr_cnt;
                        wr_cnt                          <= wr_cnt + 1'b1;
                    end
                end

                StBeam: begin
                    bus.output_read_en <= 1'b0;
                    if (bus.slice_state != 2'd0) begin
                        bus.sample_index <= bus.sample_index + 1'b1;
                    end
                    if (bus.slice_state != 2'd3) begin
                        bus.slice_state <= bus.slice_state + 1'b1;
                    end else begin
                        bus.slice_state    <= '0;
                        bus.readin_address <= bus.readin_address + 1'b1;
                        if (bus.readin_address == LastWord) begin
                            state       <= StDrain;
                            drain_timer <= '0;
                        end else begin
                            bus.output_read_en <= 1'b1;
                        end
                    end
                end

                StDrain: begin
                    drain_timer <= drain_timer + 1'b1;
                    if (good_next == TotalCnt) begin
                        bus.startbeamformer <= 1'b0;
`ifdef BFSEQ_READOUT_EN
                        state              <= StReadout;
                        bus.sumouten       <= 1'b1;
                        bus.sumout_address <= '0;
`else
                        state    <= StDone;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
`endif
                    end else if (drain_timer == DrainLast) begin
                        state               <= StDone;
                        bus.startbeamformer <= 1'b0;
                        bus.err             <= 1'b1;
                        bus.done            <= 1'b1;
                        bus.busy            <= 1'b0;
                    end
                end

`ifdef BFSEQ_READOUT_EN
                StReadout: begin
                    if (bus.sumout_address == LastSum) begin
                        state        <= StDone;
                        bus.sumouten <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                    end else begin
                        bus.sumout_address <= bus.sumout_address + 1'b1;
                    end
                end
`endif

                default: state <= StIdle;
            endcase
        end
    end
endmodule
